pht_predictor: RTL

PHT_PREDICTOR -- requirements
Module: pht_predictor

---
 rtl/pht_predictor.sv | 115 +++++++++++
 1 files changed

// File: rtl/pht_predictor.sv
// Pattern history table direction predictor.
// Two fetch slots read a table of 2-bit saturating counters indexed by
// {pc[2 +: PC_BITS], history}. Two EX slots train it. Two saturating
// performance counters track accepted updates and mispredictions.
`ifndef XLEN
`define XLEN 32
`endif

module pht_predictor #(
    parameter int BHT_WIDTH = 4,
    parameter int PC_BITS   = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [1:0][`XLEN-1:0]              if_pc_in,
    input  logic [1:0][BHT_WIDTH-1:0]          bht_if_in,
    input  logic [1:0]                         wr_en,
    input  logic [1:0][`XLEN-1:0]              ex_pc_in,
    input  logic [1:0][BHT_WIDTH-1:0]          bht_ex_in,
    input  logic [1:0]                         take_branch,
    input  logic                               perf_clear,
    output logic [1:0]                         predict_taken,
    output logic [1:0]                         mispredict,
    output logic [CNT_WIDTH-1:0]               update_cnt,
    output logic [CNT_WIDTH-1:0]               mispred_cnt
);

    localparam int IDX_W = PC_BITS + BHT_WIDTH;
    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]           pht_q [DEPTH];
    logic [1:0]           pht_d [DEPTH];
    logic [IDX_W-1:0]     if_idx [2];
    logic [IDX_W-1:0]     ex_idx [2];
    logic [1:0]           ex_pred;
    logic [1:0]           upd_inc;
    logic [1:0]           mis_inc;
    logic [CNT_WIDTH-1:0] upd_cnt_q, upd_cnt_d;
    logic [CNT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;
    logic                 unused_pc;

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
        if (up) begin
            return (c == 2'b11) ? c : c + 2'b01;
        end
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                      input logic [1:0] inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, c} + {{(CNT_WIDTH-1){1'b0}}, inc};
        return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    endfunction

    // Only pc[2 +: PC_BITS] participates in indexing; the rest is intentionally dropped.
    assign unused_pc = ^{if_pc_in, ex_pc_in};

    // Table indices and combinational read ports (pre-update values, no bypass).
    always_comb begin
        predict_taken = 2'b00;
        mispredict    = 2'b00;
        ex_pred       = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if_idx[i]        = {if_pc_in[i][2 +: PC_BITS], bht_if_in[i]};
            ex_idx[i]        = {ex_pc_in[i][2 +: PC_BITS], bht_ex_in[i]};
            predict_taken[i] = pht_q[if_idx[i]][1];
            ex_pred[i]       = pht_q[ex_idx[i]][1];
            mispredict[i]    = wr_en[i] & (ex_pred[i] != take_branch[i]);
        end
    end

    // Next table state: slot 0 applied first, slot 1 chained on its result when indices match.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            pht_d[e] = pht_q[e];
            if (wr_en[0] && (ex_idx[0] == IDX_W'(e))) begin
                pht_d[e] = sat_step(pht_d[e], take_branch[0]);
            end
            if (wr_en[1] && (ex_idx[1] == IDX_W'(e))) begin
                pht_d[e] = sat_step(pht_d[e], take_branch[1]);
            end
        end
    end

    // Performance counters: saturating, with synchronous clear taking priority.
    always_comb begin
        upd_inc   = {1'b0, wr_en[0]} + {1'b0, wr_en[1]};
        mis_inc   = {1'b0, mispredict[0]} + {1'b0, mispredict[1]};
        upd_cnt_d = perf_clear ? '0 : sat_add(upd_cnt_q, upd_inc);
        mis_cnt_d = perf_clear ? '0 : sat_add(mis_cnt_q, mis_inc);
    end

    // State registers; reset forces every entry to weakly not-taken.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                pht_q[e] <= 2'b01;
            end
            upd_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                pht_q[e] <= pht_d[e];
            end
            upd_cnt_q <= upd_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign update_cnt  = upd_cnt_q;
    assign mispred_cnt = mis_cnt_q;

endmodule
